phy_rx_deserializer: RTL



---
 rtl/phy_rx_pkg.sv | 14 +
 rtl/phy_rx_byte_shift.sv | 35 +++
 rtl/phy_rx_deserializer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/phy_rx_pkg.sv
// Shared constants and state encoding for the PHY receive deserializer.
package phy_rx_pkg;

    localparam int                BYTE_W             = 8;
    localparam int                WORD_BYTES         = 4;
    localparam logic [BYTE_W-1:0] COM_SYMBOL_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        COUNTING = 2'd1,
        LOCKED   = 2'd2
    } rx_state_e;

endpackage

// File: rtl/phy_rx_byte_shift.sv
// Serial shift register with a bit counter that marks byte boundaries once
// the receiver has chosen an alignment.
module phy_rx_byte_shift
    import phy_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              realign,
    output logic [BYTE_W-1:0] byte_now,
    output logic              byte_strobe
);

    // Only seven history bits are kept: the eighth bit of the byte is the live input.
    logic [BYTE_W-2:0] sr_q, sr_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;

    always_comb begin
        byte_now    = {sr_q, din};
        byte_strobe = (bit_cnt_q == 3'd7);
        sr_d        = byte_now[BYTE_W-2:0];
        bit_cnt_d   = realign ? 3'd0 : bit_cnt_q + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/phy_rx_deserializer.sv
// Receive-side deserializer: COM-based byte alignment, lock qualification and
// packing of data bytes into 32-bit words on the clk_32f domain.
module phy_rx_deserializer
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEFAULT,
    parameter int         N_COM      = 4,
    parameter int         MAX_ERR    = 2
)
(
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_serial_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        sincronizar_bus,
    output logic        frame_error
);

    localparam int                 IDX_W     = $clog2(WORD_BYTES);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(WORD_BYTES - 1);
    localparam logic [3:0]         N_COM_C   = 4'(N_COM);
    localparam logic [2:0]         MAX_ERR_C = 3'(MAX_ERR);
    localparam int                 LANES_W   = (WORD_BYTES - 1) * BYTE_W;

    logic [BYTE_W-1:0] byte_now;
    logic              byte_strobe;
    logic              realign;
    logic              is_com;

    rx_state_e          state_q, state_d;
    logic [3:0]         com_cnt_q, com_cnt_d;
    logic [2:0]         err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [LANES_W-1:0] lanes_q, lanes_d;
    logic [31:0]        data_out_q, data_out_d;
    logic               valid_q, valid_d;
    logic               sync_q, sync_d;
    logic               ferr_q, ferr_d;

    phy_rx_byte_shift u_shift (
        .clk         (clk_32f),
        .rst         (reset),
        .din         (data_serial_in),
        .realign     (realign),
        .byte_now    (byte_now),
        .byte_strobe (byte_strobe)
    );

    assign is_com = (byte_now == COM_SYMBOL);

    always_comb begin
        state_d    = state_q;
        com_cnt_d  = com_cnt_q;
        err_cnt_d  = err_cnt_q;
        byte_idx_d = byte_idx_q;
        lanes_d    = lanes_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        realign    = 1'b0;

        case (state_q)
            UNLOCKED: begin
                // Bit-sliding search: every cycle is a candidate boundary.
                if (is_com) begin
                    realign    = 1'b1;
                    com_cnt_d  = 4'd1;
                    err_cnt_d  = '0;
                    byte_idx_d = '0;
                    state_d    = (N_COM_C == 4'd1) ? LOCKED : COUNTING;
                end
            end
            COUNTING: begin
                if (byte_strobe) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_q + 4'd1 == N_COM_C) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        com_cnt_d = '0;
                        state_d   = UNLOCKED;
                    end
                end
            end
            LOCKED: begin
                if (byte_strobe) begin
                    if (is_com) begin
                        // A COM between words is idle fill; inside a word it breaks framing.
                        if (byte_idx_q != '0) begin
                            ferr_d     = 1'b1;
                            byte_idx_d = '0;
                            if (err_cnt_q + 3'd1 == MAX_ERR_C) begin
                                state_d   = UNLOCKED;
                                com_cnt_d = '0;
                                err_cnt_d = '0;
                                realign   = 1'b1;
                            end else begin
                                err_cnt_d = err_cnt_q + 3'd1;
                            end
                        end
                    end else if (byte_idx_q == IDX_LAST) begin
                        data_out_d = {lanes_q, byte_now};
                        valid_d    = 1'b1;
                        err_cnt_d  = '0;
                        byte_idx_d = '0;
                    end else begin
                        lanes_d    = {lanes_q[LANES_W-BYTE_W-1:0], byte_now};
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = UNLOCKED;
            end
        endcase

        sync_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            com_cnt_q  <= '0;
            err_cnt_q  <= '0;
            byte_idx_q <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            sync_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            com_cnt_q  <= com_cnt_d;
            err_cnt_q  <= err_cnt_d;
            byte_idx_q <= byte_idx_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            sync_q     <= sync_d;
            ferr_q     <= ferr_d;
        end
    end

    // Partial-word lanes are only read after byte_idx has walked from zero, so they need no reset.
    always_ff @(posedge clk_32f) begin
        lanes_q <= lanes_d;
    end

    assign data_out        = data_out_q;
    assign valid_out       = valid_q;
    assign sincronizar_bus = sync_q;
    assign frame_error     = ferr_q;

endmodule
